// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: small word FIFO feeding a start/data/parity/stop
// frame sequencer whose format is latched per frame.
module uart_tx_cfg #(
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       SYSCLK,
   input  logic       RST_B,
   input  logic [7:0] TX_DATA,
   input  logic       TX_VALID,
   output logic       TX_READY,
   input  logic [1:0] DATA_BITS,
   input  logic [1:0] PARITY_MODE,
   input  logic       STOP2,
   output logic       UART_TX_O,
   output logic       TX_BUSY,
   output logic [6:0] FIFO_LEVEL
);

   localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [6:0]  DEPTH_L  = 7'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   function automatic logic [7:0] width_mask(input logic [1:0] data_bits);
      logic [7:0] mask;
      case (data_bits)
         2'b00:   mask = 8'h1F;
         2'b01:   mask = 8'h3F;
         2'b10:   mask = 8'h7F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

   // Even parity is the XOR of the sent bits; odd mode inverts it.
   function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
      return (^data) ^ (mode == 2'b10);
   endfunction

   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [6:0]    level_r;

   state_t        state_r;
   logic [15:0]   timer_r;
   logic          line_r;
   logic [7:0]    shift_r;
   logic [2:0]    bit_idx_r;
   logic [1:0]    fmt_bits_r;
   logic          par_en_r;
   logic          par_val_r;
   logic          stop2_r;
   logic          stop_cnt_r;

   logic          push_s;
   logic          pop_s;
   logic          empty_s;
   logic          bit_end_s;
   logic          last_stop_s;
   logic [2:0]    last_idx_s;
   logic [7:0]    head_s;

   // Handshake, pop decision and the masked head word for the next frame.
   always_comb begin
      empty_s     = (level_r == 7'd0);
      bit_end_s   = (timer_r == DIV_LAST);
      push_s      = TX_VALID && (level_r != DEPTH_L);
      last_stop_s = (state_r == ST_STOP) && bit_end_s && (!stop2_r || stop_cnt_r);
      pop_s       = !empty_s && ((state_r == ST_IDLE) || last_stop_s);
      last_idx_s  = {1'b0, fmt_bits_r} + 3'd4;
      head_s      = mem_r[rd_ptr_r] & width_mask(DATA_BITS);
   end

   // FIFO storage; contents need no reset because the level gates every read.
   always_ff @(posedge SYSCLK) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= TX_DATA;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge SYSCLK or negedge RST_B) begin
      if (!RST_B) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= 7'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + 7'd1;
            2'b01:   level_r <= level_r - 7'd1;
            default: level_r <= level_r;
         endcase
      end
   end

   // Frame sequencer owning state, bit timer and the registered serial line.
   always_ff @(posedge SYSCLK or negedge RST_B) begin
      if (!RST_B) begin
         state_r    <= ST_IDLE;
         timer_r    <= 16'd0;
         line_r     <= 1'b1;
         shift_r    <= 8'd0;
         bit_idx_r  <= 3'd0;
         fmt_bits_r <= 2'b00;
         par_en_r   <= 1'b0;
         par_val_r  <= 1'b0;
         stop2_r    <= 1'b0;
         stop_cnt_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               timer_r <= 16'd0;
               line_r  <= 1'b1;
            end
            ST_START: begin
               if (bit_end_s) begin
                  state_r   <= ST_DATA;
                  timer_r   <= 16'd0;
                  bit_idx_r <= 3'd0;
                  line_r    <= shift_r[0];
               end else begin
                  timer_r <= timer_r + 16'd1;
               end
            end
            ST_DATA: begin
               if (bit_end_s) begin
                  timer_r <= 16'd0;
                  if (bit_idx_r == last_idx_s) begin
                     if (par_en_r) begin
                        state_r <= ST_PARITY;
                        line_r  <= par_val_r;
                     end else begin
                        state_r    <= ST_STOP;
                        line_r     <= 1'b1;
                        stop_cnt_r <= 1'b0;
                     end
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                     shift_r   <= {1'b0, shift_r[7:1]};
                     line_r    <= shift_r[1];
                  end
               end else begin
                  timer_r <= timer_r + 16'd1;
               end
            end
            ST_PARITY: begin
               if (bit_end_s) begin
                  state_r    <= ST_STOP;
                  timer_r    <= 16'd0;
                  line_r     <= 1'b1;
                  stop_cnt_r <= 1'b0;
               end else begin
                  timer_r <= timer_r + 16'd1;
               end
            end
            ST_STOP: begin
               if (bit_end_s) begin
                  timer_r <= 16'd0;
                  if (last_stop_s) begin
                     state_r <= ST_IDLE;
                  end else begin
                     stop_cnt_r <= 1'b1;
                  end
               end else begin
                  timer_r <= timer_r + 16'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               timer_r <= 16'd0;
               line_r  <= 1'b1;
            end
         endcase
         // A pop always starts a frame, from IDLE or straight out of the last stop bit.
         if (pop_s) begin
            state_r    <= ST_START;
            timer_r    <= 16'd0;
            line_r     <= 1'b0;
            shift_r    <= head_s;
            fmt_bits_r <= DATA_BITS;
            par_en_r   <= (PARITY_MODE == 2'b01) || (PARITY_MODE == 2'b10);
            par_val_r  <= parity_bit(head_s, PARITY_MODE);
            stop2_r    <= STOP2;
         end
      end
   end

   assign TX_READY   = (level_r != DEPTH_L);
   assign FIFO_LEVEL = level_r;
   assign UART_TX_O  = line_r;
   assign TX_BUSY    = (state_r != ST_IDLE) || !empty_s;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: accepted words are queued, and a line monitor
// rebuilds each expected frame from the format rules and checks it cycle by cycle.
module tb_uart_tx_cfg;

   localparam int DIV   = 4;
   localparam int DEPTH = 4;

   logic       SYSCLK = 1'b0;
   logic       RST_B;
   logic [7:0] TX_DATA;
   logic       TX_VALID;
   logic       TX_READY;
   logic [1:0] DATA_BITS;
   logic [1:0] PARITY_MODE;
   logic       STOP2;
   logic       UART_TX_O;
   logic       TX_BUSY;
   logic [6:0] FIFO_LEVEL;

   uart_tx_cfg #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .SYSCLK(SYSCLK), .RST_B(RST_B), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
      .TX_READY(TX_READY), .DATA_BITS(DATA_BITS), .PARITY_MODE(PARITY_MODE),
      .STOP2(STOP2), .UART_TX_O(UART_TX_O), .TX_BUSY(TX_BUSY), .FIFO_LEVEL(FIFO_LEVEL)
   );

   always #5 SYSCLK = ~SYSCLK;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] sb[$];
   int         starts[$];
   int         accepted = 0;
   int         started = 0;
   int         cyc_cnt = 0;
   int         last_push_edge = 0;
   int         last_start_edge = 0;
   logic [4:0] cfg_q = 5'd0;
   bit         in_frame = 1'b0;
   int         exp_bits[16];
   int         nb = 0;
   int         fcyc = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Edge sampler: format in force at this edge, and which pushes the FIFO takes.
   initial forever begin
      @(posedge SYSCLK);
      cfg_q = {DATA_BITS, PARITY_MODE, STOP2};
      if (RST_B === 1'b1 && TX_VALID === 1'b1 && (accepted - started) < DEPTH) begin
         sb.push_back(TX_DATA);
         accepted++;
         last_push_edge = cyc_cnt;
      end
      cyc_cnt++;
   end

   // Line monitor: on each start bit pop the next word and build its frame.
   initial forever begin
      logic [7:0] w;
      int n, wi, p, exp_level;
      @(negedge SYSCLK);
      if (RST_B !== 1'b1) begin
         in_frame = 1'b0;
      end else begin
         if (!in_frame && sb.size() == 0) begin
            check("idle_line", UART_TX_O, 1);
         end else if (!in_frame && UART_TX_O === 1'b0) begin
            w  = sb.pop_front();
            n  = int'(cfg_q[4:3]) + 5;
            wi = int'(w) % (1 << n);
            exp_bits[0] = 0;
            for (int i = 0; i < n; i++) exp_bits[1 + i] = (wi >> i) & 1;
            nb = n + 1;
            p  = int'(cfg_q[2:1]);
            if (p == 1 || p == 2) begin
               exp_bits[nb] = ($countones(wi) % 2) ^ ((p == 2) ? 1 : 0);
               nb++;
            end
            exp_bits[nb] = 1;
            nb++;
            if (cfg_q[0]) begin
               exp_bits[nb] = 1;
               nb++;
            end
            started++;
            fcyc = 0;
            in_frame = 1'b1;
            last_start_edge = cyc_cnt - 1;
            starts.push_back(cyc_cnt - 1);
         end
         if (in_frame) begin
            check("line", UART_TX_O, exp_bits[fcyc / DIV]);
            fcyc++;
         end
         exp_level = accepted - started;
         check("fifo_level", FIFO_LEVEL, exp_level);
         check("tx_busy", TX_BUSY, (in_frame || exp_level != 0) ? 1 : 0);
         if (in_frame && fcyc == nb * DIV) in_frame = 1'b0;
      end
   end

   task automatic drive_cycle(input bit v, input logic [7:0] d);
      @(negedge SYSCLK);
      #1;
      TX_VALID = v;
      TX_DATA  = d;
      if (v) check("tx_ready", TX_READY, ((accepted - started) < DEPTH) ? 1 : 0);
   endtask

   task automatic wait_idle(input string tag);
      bit done = 1'b0;
      for (int k = 0; k < 3000 && !done; k++) begin
         @(negedge SYSCLK);
         #1;
         if (sb.size() == 0 && !in_frame) done = 1'b1;
      end
      check({"drain_", tag}, done, 1);
   endtask

   task automatic run_directed(input logic [7:0] w, input logic [1:0] db,
                               input logic [1:0] pm, input logic s2, input string tag);
      drive_cycle(1'b0, 8'h00);
      DATA_BITS = db; PARITY_MODE = pm; STOP2 = s2;
      drive_cycle(1'b0, 8'h00);
      drive_cycle(1'b1, w);
      drive_cycle(1'b0, 8'h00);
      wait_idle(tag);
      check({"latency_", tag}, last_start_edge, last_push_edge + 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RST_B = 1'b0; TX_VALID = 1'b0; TX_DATA = 8'h00;
      DATA_BITS = 2'b11; PARITY_MODE = 2'b00; STOP2 = 1'b0;
      repeat (3) @(negedge SYSCLK);
      #1;
      check("reset_line", UART_TX_O, 1);
      check("reset_level", FIFO_LEVEL, 0);
      check("reset_ready", TX_READY, 1);
      check("reset_busy", TX_BUSY, 0);
      RST_B = 1'b1;

      run_directed(8'hA5, 2'b11, 2'b01, 1'b0, "a5_8e1");
      run_directed(8'h41, 2'b10, 2'b10, 1'b1, "41_7o2");
      run_directed(8'hFF, 2'b00, 2'b00, 1'b0, "ff_5n1");

      // Six back-to-back pushes: one pops immediately, four fill the FIFO, one bounces.
      drive_cycle(1'b0, 8'h00);
      DATA_BITS = 2'b11; PARITY_MODE = 2'b00; STOP2 = 1'b0;
      starts.delete();
      for (int i = 0; i < 6; i++) drive_cycle(1'b1, 8'($urandom));
      drive_cycle(1'b0, 8'h00);
      wait_idle("burst");
      check("burst_frames", starts.size(), 5);
      for (int i = 1; i < starts.size(); i++) check("burst_gap", starts[i] - starts[i-1], 10 * DIV);

      // Width change while the first of two queued frames is in its data bits.
      drive_cycle(1'b0, 8'h00);
      DATA_BITS = 2'b11; PARITY_MODE = 2'b00; STOP2 = 1'b0;
      starts.delete();
      drive_cycle(1'b1, 8'h96);
      drive_cycle(1'b1, 8'h6B);
      drive_cycle(1'b0, 8'h00);
      repeat (12) drive_cycle(1'b0, 8'h00);
      DATA_BITS = 2'b00;
      wait_idle("cfg_change");
      check("cfg_frames", starts.size(), 2);
      if (starts.size() == 2) check("cfg_first_len", starts[1] - starts[0], 10 * DIV);

      for (int c = 0; c < 800; c++) begin
         drive_cycle(($urandom_range(0, 3) == 0), 8'($urandom));
         if ($urandom_range(0, 29) == 0) begin
            DATA_BITS = 2'($urandom); PARITY_MODE = 2'($urandom); STOP2 = 1'($urandom);
         end
      end
      drive_cycle(1'b0, 8'h00);
      wait_idle("random");

      // Reset in the middle of a frame with two words still queued.
      DATA_BITS = 2'b11; PARITY_MODE = 2'b00; STOP2 = 1'b0;
      drive_cycle(1'b1, 8'h00);
      drive_cycle(1'b1, 8'h00);
      drive_cycle(1'b1, 8'h00);
      drive_cycle(1'b0, 8'h00);
      repeat (8) drive_cycle(1'b0, 8'h00);
      #3;
      RST_B = 1'b0;
      sb.delete();
      accepted = 0;
      started  = 0;
      #1;
      check("abort_line", UART_TX_O, 1);
      check("abort_level", FIFO_LEVEL, 0);
      check("abort_ready", TX_READY, 1);
      check("abort_busy", TX_BUSY, 0);
      repeat (3) @(negedge SYSCLK);
      #1;
      RST_B = 1'b1;
      repeat (40) drive_cycle(1'b0, 8'h00);
      check("post_reset_frames", started, 0);
      run_directed(8'h3C, 2'b01, 2'b01, 1'b1, "after_reset");

      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 434, giving SYSCLK cycles per bit (legal 4..65535); 434 gives 115200 baud at 50 MHz.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the transmit FIFO depth in words (power of two, 2..64).
REQ-003 SYSCLK  input  1  system clock; all state on rising edge.
REQ-004 RST_B  input  1  reset, asynchronous, active-low.
REQ-005 TX_DATA  input  8  word to send, LSB first; bits above the configured width are ignored.
REQ-006 TX_VALID  input  1  TX_DATA is valid; a word is accepted on a rising edge where TX_VALID=1 and TX_READY=1.
REQ-007 TX_READY  output  1  FIFO can accept a word.
REQ-008 DATA_BITS  input  2  data width per frame: 00=5, 01=6, 10=7, 11=8.
REQ-009 PARITY_MODE  input  2  parity mode: 00=none, 01=even, 10=odd, 11=none.
REQ-010 STOP2  input  1  0 selects one stop bit; 1 selects two stop bits.
REQ-011 UART_TX_O  output  1  serial line; idle high.
REQ-012 TX_BUSY  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
REQ-013 FIFO_LEVEL  output  7  number of words held in the FIFO (0..FIFO_DEPTH).

Function
REQ-014 FIFO: synchronous, first-in first-out.
- TX_READY = (FIFO_LEVEL != FIFO_DEPTH), combinational from the level.
- A push and a pop on the same edge leave FIFO_LEVEL unchanged.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP. Each bit SHALL last exactly CLK_DIV cycles, timed by a bit-timer counting 0..CLK_DIV-1.
REQ-016 IDLE -> START on the first edge where the FIFO is non-empty. On that edge:
- the head word is popped;
- DATA_BITS, PARITY_MODE and STOP2 are latched for the whole frame;
- UART_TX_O is registered low.
Mid-frame changes to the config inputs SHALL have no effect on the frame in progress.
REQ-017 Latency: a word accepted at edge N into an empty FIFO while the FSM is IDLE SHALL drive UART_TX_O low from edge N+1.
REQ-018 START -> DATA after 1 bit time. DATA shifts out the configured number of bits, LSB first.
REQ-019 DATA -> PARITY after the last data bit when parity is enabled; otherwise DATA -> STOP.
REQ-020 Parity value:
- even mode: XOR of the transmitted data bits;
- odd mode: its inverse.
REQ-021 STOP drives high for 1 or 2 bit times according to the latched STOP2.
REQ-022 At the end of STOP:
- FIFO non-empty: go directly to START with a new pop on the same edge, so there is zero idle cycles between frames;
- FIFO empty: go to IDLE.
REQ-023 UART_TX_O SHALL be registered (glitch-free) and SHALL be high in IDLE and STOP.
REQ-024 The bit-timer SHALL hold at 0 in IDLE and SHALL restart from 0 on every state entry.
REQ-025 A push attempted while TX_READY=0 SHALL be ignored: no overwrite, level unchanged.

Reset
REQ-026 While RST_B=0, regardless of clock:
- FIFO cleared;
- FSM = IDLE, bit-timer = 0;
- UART_TX_O=1, TX_BUSY=0, FIFO_LEVEL=0, TX_READY=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, with the line high. After release, no partial frame is resumed, and the first frame starts only after a new push.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-028 Push 0xA5, DATA_BITS=11, PARITY_MODE=01, STOP2=0 -> line shows the bits below, each exactly 4 cycles (44 cycles total); start bit low from the edge after the push; TX_BUSY falls after the stop bit:
- start 0;
- data 1,0,1,0,0,1,0,1;
- parity 0;
- stop 1.
REQ-029 Push 0x41, DATA_BITS=10, PARITY_MODE=10, STOP2=1 -> line shows 11 bits (44 cycles):
- start 0;
- data 1,0,0,0,0,0,1;
- parity 1;
- stop 1,1.
REQ-030 Push 0xFF, DATA_BITS=00, PARITY_MODE=00, STOP2=0 -> line shows 7 bits (28 cycles): start 0; data 1,1,1,1,1; stop 1. Upper 3 bits are not sent.
REQ-031 Back-to-back and FIFO-full:
- Push 6 words on consecutive cycles -> TX_READY=0 once FIFO_LEVEL=4; further pushes ignored.
- Exactly 5 frames are sent, in order, with no idle cycle between them.
- FIFO_LEVEL then steps 4 -> 0.
REQ-032 Config change mid-frame: change DATA_BITS from 11 to 00 during DATA of a frame -> current frame still sends 8 data bits; next frame sends 5.
REQ-033 Reset mid-frame: assert RST_B low during DATA with 2 words queued -> UART_TX_O=1 and FIFO_LEVEL=0 asynchronously; after release, the line stays high with no frame until a new push.
